// File: rtl/dlx_trace_buffer.sv
// rtl/dlx_trace_buffer.sv - multi-channel DLX trace capture FIFO with halt/post-trigger freeze
module dlx_trace_buffer #(
  parameter int NCH   = 2,
  parameter int AW    = 16,
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int POST  = 8
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic [NCH-1:0]                           ch_valid,
  input  logic [NCH*AW-1:0]                        ch_addr,
  input  logic [NCH*DW-1:0]                        ch_data,
  input  logic [NCH*2-1:0]                         ch_tag,
  input  logic                                     halt,
  input  logic                                     arm,
  input  logic                                     out_ready,
  output logic                                     out_valid,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] out_ch,
  output logic [AW-1:0]                            out_addr,
  output logic [DW-1:0]                            out_data,
  output logic [1:0]                               out_tag,
  output logic                                     out_lost,
  output logic [$clog2(DEPTH):0]                   count,
  output logic [1:0]                               state,
  output logic [15:0]                              drop_cnt
);

  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int EW   = 1 + 2 + DW + AW + CW;
  localparam logic [CNTW-1:0] FULL   = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] POST_V = CNTW'(POST);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_POST   = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d, post_q, post_d;
  logic [15:0]     drop_q, drop_d;
  logic            pend_q, pend_d;
  logic [CW-1:0]   rr_q, rr_d, grant_ch;
  logic            grant, push, pop, capture_en;
  logic [2:0]      nvalid, ndrop;
  logic [16:0]     drop_sum;
  logic [EW-1:0]   wr_entry, head;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic [1:0]      sel_tag;
  int              idx;
  logic [EW-1:0]   mem_q [DEPTH];

  // Round-robin search starts at rr_q, the channel after the last grant.
  always_comb begin
    grant    = 1'b0;
    grant_ch = '0;
    nvalid   = '0;
    idx      = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      for (int j = 0; j < NCH; j++) begin
        if (j == idx && ch_valid[j] && !grant) begin
          grant    = 1'b1;
          grant_ch = CW'(j);
        end
      end
      nvalid = nvalid + 3'(ch_valid[i]);
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_tag  = '0;
    for (int j = 0; j < NCH; j++) begin
      if (grant_ch == CW'(j)) begin
        sel_addr = ch_addr[j*AW +: AW];
        sel_data = ch_data[j*DW +: DW];
        sel_tag  = ch_tag[j*2 +: 2];
      end
    end
    wr_entry = {pend_q, sel_tag, sel_data, sel_addr, grant_ch};
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign out_ch    = head[CW-1:0];
  assign out_addr  = head[CW +: AW];
  assign out_data  = head[CW+AW +: DW];
  assign out_tag   = head[CW+AW+DW +: 2];
  assign out_lost  = head[EW-1];
  assign count     = count_q;
  assign state     = state_q;
  assign drop_cnt  = drop_q;

  assign capture_en = (state_q != ST_FROZEN);
  assign pop        = out_valid && out_ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push       = capture_en && grant && ((count_q != FULL) || pop);
  assign ndrop      = capture_en ? (nvalid - 3'(push)) : 3'd0;
  assign drop_sum   = {1'b0, drop_q} + 17'(ndrop);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
    rr_d    = (capture_en && grant) ?
              ((int'(grant_ch) == NCH - 1) ? '0 : grant_ch + CW'(1)) : rr_q;
    drop_d  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    pend_d  = (pend_q && !push) || (ndrop != 3'd0);
    state_d = state_q;
    post_d  = post_q;
    unique case (state_q)
      ST_RUN: begin
        if (halt) begin
          if (POST == 0) begin
            state_d = ST_FROZEN;
          end else begin
            state_d = ST_POST;
            post_d  = POST_V;
          end
        end
      end
      ST_POST: begin
        if (push) begin
          post_d = post_q - CNTW'(1);
          if (post_q == CNTW'(1)) state_d = ST_FROZEN;
        end
      end
      default: begin
        if (arm && count_q == '0) begin
          state_d = ST_RUN;
          drop_d  = '0;
          pend_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      post_q   <= '0;
      drop_q   <= '0;
      pend_q   <= 1'b0;
      rr_q     <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      post_q   <= post_d;
      drop_q   <= drop_d;
      pend_q   <= pend_d;
      rr_q     <= rr_d;
    end
  end

  // Entry storage is left uninitialised; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

endmodule

// File: tb/tb_dlx_trace_buffer.sv
// tb/tb_dlx_trace_buffer.sv - randomized bench for dlx_trace_buffer against a queue model
module tb_dlx_trace_buffer;
  localparam int NCH = 2, AW = 16, DW = 32, DEPTH = 16, POST = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic [NCH-1:0] ch_valid;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH*2-1:0] ch_tag;
  logic halt, arm, out_ready;
  logic out_valid, out_lost;
  logic [0:0] out_ch;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic [1:0] out_tag, dut_state;
  logic [4:0] count;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  dlx_trace_buffer #(.NCH(NCH), .AW(AW), .DW(DW), .DEPTH(DEPTH), .POST(POST)) dut (
    .clk(clk), .reset_n(reset_n), .ch_valid(ch_valid), .ch_addr(ch_addr),
    .ch_data(ch_data), .ch_tag(ch_tag), .halt(halt), .arm(arm),
    .out_ready(out_ready), .out_valid(out_valid), .out_ch(out_ch),
    .out_addr(out_addr), .out_data(out_data), .out_tag(out_tag),
    .out_lost(out_lost), .count(count), .state(dut_state), .drop_cnt(drop_cnt)
  );

  typedef struct {
    int            ch;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    tag;
    bit            lost;
  } ent_t;

  ent_t mq[$];
  int   m_state, m_drop, m_rr, m_post;
  bit   m_pend;
  int   n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_state = 0; m_drop = 0; m_rr = 0; m_post = 0; m_pend = 0;
  endtask

  task automatic model_step();
    int   cnt0, g, nd, c;
    bit   cap, do_pop, do_push;
    ent_t e;
    cnt0 = mq.size();
    cap  = (m_state != 2);
    g    = -1;
    if (cap) begin
      for (int k = 0; k < NCH; k++) begin
        c = (m_rr + k) % NCH;
        if (g < 0 && ch_valid[c]) g = c;
      end
    end
    do_pop  = (cnt0 > 0) && out_ready;
    do_push = (g >= 0) && ((cnt0 < DEPTH) || do_pop);
    nd      = cap ? ($countones(ch_valid) - int'(do_push)) : 0;
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      e.ch   = g;
      e.addr = ch_addr[g*AW +: AW];
      e.data = ch_data[g*DW +: DW];
      e.tag  = ch_tag[g*2 +: 2];
      e.lost = m_pend;
      mq.push_back(e);
      m_pend = 0;
    end
    if (nd > 0) m_pend = 1;
    m_drop = (m_drop + nd > 65535) ? 65535 : m_drop + nd;
    if (g >= 0) m_rr = (g + 1) % NCH;
    case (m_state)
      0: if (halt) begin
        if (POST == 0) m_state = 2;
        else begin m_state = 1; m_post = POST; end
      end
      1: if (do_push) begin
        m_post--;
        if (m_post == 0) m_state = 2;
      end
      default: if (arm && cnt0 == 0) begin
        m_state = 0; m_drop = 0; m_pend = 0;
      end
    endcase
  endtask

  task automatic compare();
    check("out_valid", out_valid, mq.size() != 0);
    check("count", count, mq.size());
    check("state", dut_state, m_state);
    check("drop_cnt", drop_cnt, m_drop);
    if (mq.size() != 0) begin
      check("out_ch", out_ch, mq[0].ch);
      check("out_addr", out_addr, mq[0].addr);
      check("out_data", out_data, mq[0].data);
      check("out_tag", out_tag, mq[0].tag);
      check("out_lost", out_lost, mq[0].lost);
    end
  endtask

  task automatic drive(input logic [NCH-1:0] v, input logic rdy, input logic h, input logic a);
    ch_valid  = v;
    out_ready = rdy;
    halt      = h;
    arm       = a;
    ch_addr   = {$urandom, $urandom};
    ch_data   = {$urandom, $urandom};
    ch_tag    = 4'($urandom);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_reset();
    drive('0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    compare();
  endtask

  initial begin
    reset_n = 1'b0;
    drive('0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #12;
    check("rst_valid", out_valid, 1'b0);
    check("rst_count", count, 0);
    check("rst_state", dut_state, 0);
    check("rst_drop", drop_cnt, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // two channels colliding
    drive(2'b11, 1'b0, 1'b0, 1'b0); cycle();
    check("rr_first_ch", out_ch, 0);
    check("rr_first_drop", drop_cnt, 1);
    drive(2'b11, 1'b0, 1'b0, 1'b0); cycle();
    check("rr_second_count", count, 2);
    check("rr_second_drop", drop_cnt, 2);
    drive(2'b00, 1'b1, 1'b0, 1'b0); cycle();
    check("rr_second_ch", out_ch, 1);
    check("rr_second_lost", out_lost, 1'b1);

    // full without and with simultaneous pop
    do_reset();
    for (int i = 0; i < 17; i++) begin drive(2'b01, 1'b0, 1'b0, 1'b0); cycle(); end
    check("full_nopop_count", count, 16);
    check("full_nopop_drop", drop_cnt, 1);
    do_reset();
    for (int i = 0; i < 17; i++) begin drive(2'b01, i == 16, 1'b0, 1'b0); cycle(); end
    check("full_pop_count", count, 16);
    check("full_pop_drop", drop_cnt, 0);

    // post-trigger capture, freeze and re-arm
    do_reset();
    drive(2'b11, 1'b0, 1'b0, 1'b0); cycle();
    drive(2'b00, 1'b0, 1'b1, 1'b0); cycle();
    check("post_entered", dut_state, 1);
    for (int i = 0; i < 5; i++) begin
      drive(2'b01, 1'b0, 1'b0, 1'b0); cycle();
      if (i == 2) check("post_frozen", dut_state, 2);
    end
    check("post_count", count, 4);
    check("post_drop", drop_cnt, 1);
    for (int i = 0; i < 2; i++) begin drive(2'b00, 1'b1, 1'b0, 1'b0); cycle(); end
    drive(2'b00, 1'b0, 1'b0, 1'b1); cycle();
    check("arm_ignored", dut_state, 2);
    for (int i = 0; i < 2; i++) begin drive(2'b00, 1'b1, 1'b0, 1'b0); cycle(); end
    drive(2'b00, 1'b0, 1'b0, 1'b1); cycle();
    check("arm_state", dut_state, 0);
    check("arm_drop", drop_cnt, 0);

    // asynchronous reset mid-cycle
    for (int i = 0; i < 10; i++) begin drive(2'b01, 1'b0, 1'b0, 1'b0); cycle(); end
    check("prefill_count", count, 10);
    drive(2'b00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_valid", out_valid, 1'b0);
    check("async_count", count, 0);
    check("async_state", dut_state, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    compare();
    drive(2'b01, 1'b0, 1'b0, 1'b0); cycle();
    check("first_capture", count, 1);

    // pointer wrap with random drain
    for (int i = 0; i < 200; i++) begin
      drive({1'b0, 1'($urandom)}, 1'($urandom), 1'b0, 1'b0); cycle();
    end

    // fully random traffic with occasional halt and arm
    for (int i = 0; i < 600; i++) begin
      drive(2'($urandom), 1'($urandom), $urandom_range(0, 29) == 0,
            $urandom_range(0, 3) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dlx_trace_buffer.md
DLX_TRACE_BUFFER -- requirements
Module: dlx_trace_buffer

Interface
REQ-001 Parameter NCH, default 2, number of trace channels (1..4).
REQ-002 Parameter AW, default 16, channel address width.
REQ-003 Parameter DW, default 32, channel data width.
REQ-004 Parameter DEPTH, default 16, FIFO entries; power of two, minimum 4.
REQ-005 Parameter POST, default 8, entries captured after halt before freeze (0..DEPTH).
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 ch_valid  in  NCH  per-channel capture request, one cycle per event.
REQ-009 ch_addr  in  NCH*AW  per-channel address (NPC or DM_addr_eff); channel k in bits [k*AW +: AW].
REQ-010 ch_data  in  NCH*DW  per-channel data (IR, DM write data or DM read data).
REQ-011 ch_tag  in  NCH*2  event kind: 0 fetch, 1 DM read, 2 DM write, 3 user.
REQ-012 halt  in  1  stop request (CLI-equivalent); starts post-trigger capture.
REQ-013 arm  in  1  re-arm request, honoured only in FROZEN.
REQ-014 out_ready  in  1  drain side accepts the head entry.
REQ-015 out_valid  out  1  head entry present.
REQ-016 out_ch  out  max(1,clog2(NCH))  source channel of the head entry.
REQ-017 out_addr/out_data/out_tag  out  AW/DW/2  head entry fields.
REQ-018 out_lost  out  1  at least one event was dropped before this entry.
REQ-019 count  out  clog2(DEPTH)+1  current occupancy.
REQ-020 state  out  2  0 RUN, 1 POST, 2 FROZEN.
REQ-021 drop_cnt  out  16  dropped-event counter, saturating at 16'hFFFF.

Function
REQ-022 FIFO is first-word-fall-through: out_valid = (count != 0); head fields are combinational from the read pointer.
REQ-023 Pop occurs on a cycle with out_valid && out_ready; push on a cycle with a granted capture and space available.
REQ-024 A captured event appears at the head no earlier than the cycle after its ch_valid cycle (1-cycle latency when empty).
REQ-025 At most one capture per cycle; grant is round-robin among asserted ch_valid, starting at the channel after the last granted one (channel 0 first after reset).
REQ-026 Every asserted ch_valid not pushed in RUN/POST counts as one drop; drop_cnt adds the number of such channels per cycle, saturating.
REQ-027 Full FIFO with simultaneous pop: push is accepted and count remains DEPTH; full without pop: granted event dropped.
REQ-028 Simultaneous push and pop on a non-empty, non-full FIFO leaves count unchanged.
REQ-029 Any drop sets a sticky pending-lost flag; the next pushed entry stores lost=1 and clears the flag (flag set again if that same cycle also drops).
REQ-030 Read/write pointers wrap modulo DEPTH; count distinguishes full from empty.
REQ-031 RUN: capture enabled; halt -> POST with post counter = POST, or straight to FROZEN when POST = 0.
REQ-032 POST: capture enabled; each push decrements post counter; push taking it to 0 -> FROZEN that same edge.
REQ-033 FROZEN: no capture and no drop counting; drain continues; arm with count = 0 -> RUN, drop_cnt and pending-lost cleared; arm with count != 0 ignored.
REQ-034 halt in POST or FROZEN and arm in RUN or POST are ignored.

Reset
REQ-035 reset_n low asynchronously forces: pointers 0, count 0, out_valid 0, state RUN, drop_cnt 0, pending-lost 0, round-robin pointer 0, post counter 0.
REQ-036 Reset mid-operation discards all stored entries; FIFO storage contents need not be cleared.
REQ-037 First capture is possible on the first rising edge after reset_n deasserts.

Verification
REQ-038 NCH=2; ch_valid=2'b11 for one cycle, out_ready=0 -> one entry from ch0, drop_cnt=1; next cycle 2'b11 -> entry from ch1 with out_lost=1, drop_cnt=2.
REQ-039 DEPTH=16, ch0 valid 17 consecutive cycles, out_ready=0 -> count=16, drop_cnt=1; 17th cycle with out_ready=1 instead -> count stays 16, drop_cnt=0.
REQ-040 POST=3: halt pulse then ch0 valid 5 cycles -> state 1 then 2; exactly 3 entries after halt, drop_cnt unchanged by the last 2.
REQ-041 FROZEN, count=2: arm -> state stays 2; drain both, arm -> state 0, drop_cnt=0.
REQ-042 Fill 10 entries, pulse reset_n low mid-cycle -> out_valid=0, count=0 immediately, state 0.
REQ-043 Wrap: push/pop 40 entries with random out_ready -> output order and addr/data/tag identical to input sequence.
